// File: rtl/snake_head_mover.sv
// snake_head_mover: snake head position stepper with IDLE/RUN/PAUSED control, direction filtering and grid wrap-around
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset
//   dir_in   : requested direction (00 up, 01 down, 10 right, 11 left)
//   start    : leaves IDLE for RUN
//   pause    : level, freezes movement while high
//   halt     : pulse, returns to IDLE and the home cell
//   head_x/y : current head cell (y = 0 is the top row)
//   cur_dir  : committed direction
//   step     : one-cycle pulse in the cycle the new cell is shown
//   running  : high in RUN only
module snake_head_mover #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MOVE_DIV = 25000000,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir_in,
  input  logic       start,
  input  logic       pause,
  input  logic       halt,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [1:0] cur_dir,
  output logic       step,
  output logic       running
);
  localparam int CW = $clog2(MOVE_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(MOVE_DIV - 1);
  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);
  localparam logic [4:0] X_HOME = 5'(START_X);
  localparam logic [4:0] Y_HOME = 5'(START_Y);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0] pending;
  logic active, adv, do_step, opp;
  logic [4:0] x_nx, y_nx;
  // A cycle counts toward the next step whenever the block is out of IDLE and
  // pause is low; the edge that resumes from PAUSED therefore also counts, so a
  // step held back by pause lands in the first RUN cycle after resume.
  always_comb begin
    active = state != IDLE;
    adv = active && !pause && !halt;
    do_step = adv && cnt == CNT_MAX;
    state_nx = halt ? IDLE : state == IDLE ? (start ? RUN : IDLE) : pause ? PAUSED : RUN;
    // opposite pairs differ only in the low bit
    opp = (dir_in ^ cur_dir) == 2'b01;
    x_nx = pending == 2'b10 ? (head_x == X_MAX ? 5'd0 : head_x + 5'd1) :
           pending == 2'b11 ? (head_x == 5'd0 ? X_MAX : head_x - 5'd1) : head_x;
    y_nx = pending == 2'b00 ? (head_y == 5'd0 ? Y_MAX : head_y - 5'd1) :
           pending == 2'b01 ? (head_y == Y_MAX ? 5'd0 : head_y + 5'd1) : head_y;
    running = state == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst || halt) begin
      state <= IDLE;
      cnt <= '0;
      pending <= 2'b00;
      cur_dir <= 2'b00;
      head_x <= X_HOME;
      head_y <= Y_HOME;
      step <= 1'b0;
    end else begin
      state <= state_nx;
      step <= do_step;
      if (active && !opp) pending <= dir_in;
      if (adv) cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
      if (do_step) begin
        cur_dir <= pending;
        head_x <= x_nx;
        head_y <= y_nx;
      end
    end
  end
endmodule

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover: directed table-driven check of snake_head_mover on an 8x6 grid with MOVE_DIV=4
module tb_snake_head_mover;
  logic clk = 1'b0;
  logic rst, start, pause, halt;
  logic [1:0] dir_in;
  logic [4:0] head_x, head_y;
  logic [1:0] cur_dir;
  logic step, running;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [1:0] dir;
    int x;
    int y;
    int d;
  } vec_t;
  vec_t v[25];
  snake_head_mover #(.GRID_W(8), .GRID_H(6), .MOVE_DIV(4), .START_X(4), .START_Y(3)) dut (
    .clk(clk), .rst(rst), .dir_in(dir_in), .start(start), .pause(pause), .halt(halt),
    .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir), .step(step), .running(running)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 20);
  endtask
  task automatic chk_idle(input string name);
    chk({name, " running"}, int'(running), 0);
    chk({name, " step"}, int'(step), 0);
    chk({name, " x"}, int'(head_x), 4);
    chk({name, " y"}, int'(head_y), 3);
    chk({name, " dir"}, int'(cur_dir), 0);
  endtask
  initial begin
    int n;
    v[0]  = '{2'b10, 5, 3, 2};
    v[1]  = '{2'b10, 6, 3, 2};
    v[2]  = '{2'b10, 7, 3, 2};
    v[3]  = '{2'b10, 0, 3, 2};
    v[4]  = '{2'b11, 1, 3, 2};
    v[5]  = '{2'b11, 2, 3, 2};
    v[6]  = '{2'b00, 2, 2, 0};
    v[7]  = '{2'b01, 2, 1, 0};
    v[8]  = '{2'b00, 2, 0, 0};
    v[9]  = '{2'b00, 2, 5, 0};
    v[10] = '{2'b11, 1, 5, 3};
    v[11] = '{2'b01, 1, 0, 1};
    v[12] = '{2'b10, 2, 0, 2};
    v[13] = '{2'b11, 3, 0, 2};
    v[14] = '{2'b10, 4, 0, 2};
    v[15] = '{2'b00, 4, 5, 0};
    v[16] = '{2'b11, 3, 5, 3};
    v[17] = '{2'b01, 3, 0, 1};
    v[18] = '{2'b10, 4, 0, 2};
    v[19] = '{2'b01, 4, 1, 1};
    v[20] = '{2'b01, 4, 2, 1};
    v[21] = '{2'b01, 4, 3, 1};
    v[22] = '{2'b01, 4, 4, 1};
    v[23] = '{2'b01, 4, 5, 1};
    v[24] = '{2'b01, 4, 0, 1};
    rst = 1'b1; start = 1'b0; pause = 1'b0; halt = 1'b0; dir_in = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");
    dir_in = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start running", int'(running), 1);
    chk("start step", int'(step), 0);
    for (int i = 0; i < 25; i++) begin
      dir_in = v[i].dir;
      wait_step(n);
      chk($sformatf("v%0d wait", i), n, 4);
      chk($sformatf("v%0d x", i), int'(head_x), v[i].x);
      chk($sformatf("v%0d y", i), int'(head_y), v[i].y);
      chk($sformatf("v%0d dir", i), int'(cur_dir), v[i].d);
    end
    @(negedge clk);
    chk("step one cycle", int'(step), 0);
    repeat (2) @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pause step", int'(step), 0);
      chk("pause running", int'(running), 0);
      chk("pause y", int'(head_y), 0);
    end
    pause = 1'b0;
    @(negedge clk);
    chk("resume step", int'(step), 1);
    chk("resume running", int'(running), 1);
    chk("resume y", int'(head_y), 1);
    repeat (2) @(negedge clk);
    halt = 1'b1; start = 1'b1;
    @(negedge clk);
    halt = 1'b0; start = 1'b0;
    chk_idle("halt");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt idle step", int'(step), 0);
      chk("halt idle running", int'(running), 0);
    end
    dir_in = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst mid run");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst idle step", int'(step), 0);
      chk("rst idle x", int'(head_x), 4);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_step(n);
    chk("restart wait", n, 4);
    chk("restart x", int'(head_x), 5);
    chk("restart y", int'(head_y), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
